// File: rtl/picoblaze_irq_pkg.sv
// Shared constants for the Picoblaze interrupt controller: register offsets,
// FSM state encoding and source limits.
package picoblaze_irq_pkg;

  localparam int unsigned MAX_SOURCES = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned STATE_W     = 2;

  localparam logic [7:0] REG_STATUS = 8'd0;
  localparam logic [7:0] REG_MASK   = 8'd1;
  localparam logic [7:0] REG_CLEAR  = 8'd2;
  localparam logic [7:0] REG_VECTOR = 8'd3;
  localparam logic [7:0] REG_SET    = 8'd4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_ASSERT   = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_CLR = 2'd2;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest-numbered one.
module irq_priority_enc
  import picoblaze_irq_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 8
) (
  input  logic [NUM_SOURCES-1:0] req,
  output logic                   any,
  output logic [ID_W-1:0]        id
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/picoblaze_irq_ctrl.sv
// Interrupt controller for KCPSM6: edge-detected pending latch, mask,
// fixed-priority selection, interrupt/ack handshake and port-bus registers.
module picoblaze_irq_ctrl
  import picoblaze_irq_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 8,
  parameter logic [7:0]  BASE_ADDR   = 8'h10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [7:0]             port_id,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [7:0]             out_port,
  output logic [7:0]             in_port,
  output logic                   interrupt,
  input  logic                   interrupt_ack
);

  localparam int unsigned N = NUM_SOURCES;

  logic [N-1:0]       irq_src_q;
  logic [N-1:0]       pending;
  logic [N-1:0]       mask;
  logic [N-1:0]       rise;
  logic [N-1:0]       wr_data;
  logic [N-1:0]       clr_bits;
  logic [N-1:0]       set_bits;
  logic [N-1:0]       req;
  logic [7:0]         offset;
  logic [7:0]         pending_ext;
  logic [7:0]         mask_ext;
  logic [7:0]         vector;
  logic [7:0]         rd_data;
  logic               wr_mask;
  logic               wr_clear;
  logic               wr_set;
  logic               busy;
  logic               win_any;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    active_id;
  logic [ID_W-1:0]    active_id_nxt;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               interrupt_nxt;
  logic               unused_rd;

  // Reads carry no side effects, so the read strobe is not needed.
  assign unused_rd = read_strobe;

  // Offset wraps modulo 256, so only BASE_ADDR..BASE_ADDR+4 hit a register.
  assign offset   = 8'(port_id - BASE_ADDR);
  assign wr_data  = out_port[N-1:0];
  assign wr_mask  = write_strobe && (offset == REG_MASK);
  assign wr_clear = write_strobe && (offset == REG_CLEAR);
  assign wr_set   = write_strobe && (offset == REG_SET);
  assign clr_bits = wr_clear ? wr_data : '0;
  assign set_bits = wr_set ? wr_data : '0;

  assign rise        = irq_src & ~irq_src_q;
  assign req         = pending & mask;
  assign pending_ext = 8'(pending);
  assign mask_ext    = 8'(mask);
  assign busy        = (state == ST_ASSERT) || (state == ST_WAIT_CLR);
  assign vector      = {busy, 4'b0000, active_id};

  irq_priority_enc #(
    .NUM_SOURCES(N)
  ) u_prio (
    .req (req),
    .any (win_any),
    .id  (win_id)
  );

  // Read mux; CLEAR, SET and unmapped offsets read as zero.
  always_comb begin
    rd_data = 8'h00;
    case (offset)
      REG_STATUS: rd_data = pending_ext;
      REG_MASK:   rd_data = mask_ext;
      REG_VECTOR: rd_data = vector;
      default:    rd_data = 8'h00;
    endcase
  end

  // Hardware edges and software sets win over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_src_q <= '0;
      pending   <= '0;
      mask      <= '0;
      in_port   <= 8'h00;
    end else begin
      irq_src_q <= irq_src;
      pending   <= (pending & ~clr_bits) | set_bits | rise;
      if (wr_mask) begin
        mask <= wr_data;
      end
      in_port   <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= state_nxt;
      interrupt <= interrupt_nxt;
      active_id <= active_id_nxt;
    end
  end

  // Request is held until ack regardless of later mask/clear changes.
  always_comb begin
    state_nxt     = state;
    interrupt_nxt = 1'b0;
    active_id_nxt = active_id;
    case (state)
      ST_IDLE: begin
        if (win_any) begin
          state_nxt     = ST_ASSERT;
          interrupt_nxt = 1'b1;
          active_id_nxt = win_id;
        end
      end
      ST_ASSERT: begin
        interrupt_nxt = 1'b1;
        if (interrupt_ack) begin
          state_nxt     = ST_WAIT_CLR;
          interrupt_nxt = 1'b0;
        end
      end
      ST_WAIT_CLR: begin
        if (!pending_ext[active_id]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
